// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-back block: default widths,
// register index type and the write-back entry {rd, data}.
package regfile_writeback_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SIZE  = 32;
    localparam int DEF_IW    = $clog2(DEF_SIZE);

    typedef logic [DEF_IW-1:0] rf_index_t;

    typedef struct packed {
        rf_index_t            rd;
        logic [DEF_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Load-result FIFO of write-back entries; pointers carry one extra wrap bit
// so full/empty are distinguished without a separate counter.
module regfile_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int EW    = 37
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [EW-1:0] push_data,
    input  logic          pop,
    output logic [EW-1:0] pop_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results into the register file's single write port and
// keeps a pending-bit scoreboard for decode hazards. Optional forwarding
// outputs are enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SIZE   = DEF_SIZE,
    parameter int QDEPTH = 4,
    localparam int IW    = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             iss_valid,
    input  logic [IW-1:0]    iss_rd,
    input  logic             alu_valid,
    input  logic [IW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [IW-1:0]    ld_rd,
    input  logic [WIDTH-1:0] ld_data,
    output logic             wr_en,
    output logic [IW-1:0]    wr_index,
    output logic [WIDTH-1:0] wr_data,
    input  logic [IW-1:0]    rs1_index,
    input  logic [IW-1:0]    rs2_index,
    output logic             rs1_busy,
    output logic             rs2_busy,
`ifdef REGFILE_WB_BYPASS_EN
    output logic             rs1_fwd_valid,
    output logic             rs2_fwd_valid,
    output logic [WIDTH-1:0] rs1_fwd_data,
    output logic [WIDTH-1:0] rs2_fwd_data,
`endif
    output logic             overflow
);
    typedef struct packed {
        logic [IW-1:0]    rd;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t          alu_entry;
    entry_t          ld_entry;
    entry_t          head;
    entry_t          sel;
    logic            sel_valid;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [SIZE-1:0] pending;
    logic [SIZE-1:0] pending_next;
    logic [SIZE-1:0] set_mask;
    logic [SIZE-1:0] clr_mask;
    logic            collide;

    assign alu_entry = entry_t'({alu_rd, alu_data});
    assign ld_entry  = entry_t'({ld_rd, ld_data});
    assign ld_ready  = !fifo_full;

    regfile_wb_fifo #(
        .DEPTH (QDEPTH),
        .EW    (IW + WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ld_valid),
        .push_data (ld_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ALU always wins; the FIFO head is only popped in cycles the ALU is idle.
    always_comb begin
        sel_valid = 1'b0;
        pop       = 1'b0;
        sel       = head;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel       = alu_entry;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            pop       = 1'b1;
        end
    end

    // Clear is applied before set, so a same-cycle set on the written index wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wr_en) clr_mask[wr_index] = 1'b1;
        if (iss_valid && (iss_rd != '0)) set_mask[iss_rd] = 1'b1;
        pending_next    = (pending & ~clr_mask) | set_mask;
        pending_next[0] = 1'b0;
        collide = iss_valid && (iss_rd != '0) && pending[iss_rd] && !clr_mask[iss_rd];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en    <= 1'b0;
            wr_index <= '0;
            wr_data  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            wr_en <= sel_valid && (sel.rd != '0);
            if (sel_valid) begin
                wr_index <= sel.rd;
                wr_data  <= sel.data;
            end
            pending <= pending_next;
            if (collide) overflow <= 1'b1;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign rs1_fwd_valid = wr_en && (rs1_index == wr_index) && (rs1_index != '0);
    assign rs2_fwd_valid = wr_en && (rs2_index == wr_index) && (rs2_index != '0);
    assign rs1_fwd_data  = wr_data;
    assign rs2_fwd_data  = wr_data;
    assign rs1_busy = (rs1_index != '0) && pending[rs1_index] && !rs1_fwd_valid;
    assign rs2_busy = (rs2_index != '0) && pending[rs2_index] && !rs2_fwd_valid;
`else
    assign rs1_busy = (rs1_index != '0) && pending[rs1_index];
    assign rs2_busy = (rs2_index != '0) && pending[rs2_index];
`endif

endmodule
